// File: rtl/bulls_cows_game.sv
// Bulls-and-cows round controller: latches a secret, scores guesses one digit per cycle,
// and scans bulls / cows / tries / status onto a 4-digit 7-segment display.
// state | meaning
// IDLE  | no secret loaded yet
// READY | waiting for a guess
// BULL  | exact-position matches counted
// COW   | one guess digit per cycle matched against unused non-bull secret digits
// DONE  | publish score, advance tries, pick outcome
// WON   | every digit matched; held until the next secret load
// LOST  | tries exhausted; held until the next secret load

module sevenSegment (
   input  logic [3:0] i_num,
   output logic [7:0] o_ssd
);
   // active-low segments {dp,g,f,e,d,c,b,a}, decimal point off
   always_comb begin
      o_ssd = 8'hFF;
      case (i_num)
         4'h0: o_ssd = 8'hC0;
         4'h1: o_ssd = 8'hF9;
         4'h2: o_ssd = 8'hA4;
         4'h3: o_ssd = 8'hB0;
         4'h4: o_ssd = 8'h99;
         4'h5: o_ssd = 8'h92;
         4'h6: o_ssd = 8'h82;
         4'h7: o_ssd = 8'hF8;
         4'h8: o_ssd = 8'h80;
         4'h9: o_ssd = 8'h90;
         4'hA: o_ssd = 8'h88;
         4'hB: o_ssd = 8'h83;
         4'hC: o_ssd = 8'hC6;
         4'hD: o_ssd = 8'hA1;
         4'hE: o_ssd = 8'h86;
         default: o_ssd = 8'h8E;
      endcase
   end
endmodule

module bulls_cows_game #(
   parameter int DIGITS    = 4,
   parameter int DIGIT_W   = 4,
   parameter int MAX_TRIES = 8,
   parameter int SCAN_DIV  = 50000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DIGITS*DIGIT_W-1:0]   secret,
   input  logic                        secret_load,
   input  logic [DIGITS*DIGIT_W-1:0]   guess,
   input  logic                        guess_valid,
   output logic                        guess_ready,
   output logic [3:0]                  bulls,
   output logic [3:0]                  cows,
   output logic                        result_valid,
   output logic [3:0]                  tries,
   output logic                        win,
   output logic                        lose,
   output logic [7:0]                  SSD,
   output logic [3:0]                  d
);
   localparam int STEP_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [2:0] {IDLE, READY, BULL, COW, DONE, WON, LOST} state_t;

   state_t                      r_state;
   logic [DIGITS*DIGIT_W-1:0]   r_secret;
   logic [DIGITS*DIGIT_W-1:0]   r_guess;
   logic [DIGITS-1:0]           r_bull_mask;
   logic [DIGITS-1:0]           r_used;
   logic [STEP_W-1:0]           r_step;
   logic [3:0]                  r_bull_cnt;
   logic [3:0]                  r_cow_cnt;
   logic [3:0]                  r_bulls;
   logic [3:0]                  r_cows;
   logic [3:0]                  r_tries;
   logic                        r_result_valid;
   logic                        r_win;
   logic                        r_lose;
   logic [SCAN_W-1:0]           r_scan;
   logic [1:0]                  r_dig_idx;

   logic [DIGIT_W-1:0]          w_sec_dig [DIGITS];
   logic [DIGIT_W-1:0]          w_gss_dig [DIGITS];
   logic [DIGITS-1:0]           w_bull_mask;
   logic [3:0]                  w_bull_pop;
   logic                        w_found;
   logic [STEP_W-1:0]           w_match;
   logic [3:0]                  w_tries_nxt;
   logic [3:0]                  w_digit_val;

   always_comb begin
      w_bull_pop = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         w_sec_dig[k]   = r_secret[k*DIGIT_W +: DIGIT_W];
         w_gss_dig[k]   = r_guess[k*DIGIT_W +: DIGIT_W];
         w_bull_mask[k] = (w_sec_dig[k] == w_gss_dig[k]);
         w_bull_pop     = w_bull_pop + {3'd0, w_bull_mask[k]};
      end
   end

   // descending scan so the lowest qualifying secret position wins
   always_comb begin
      w_found = 1'b0;
      w_match = '0;
      for (int j = DIGITS - 1; j >= 0; j--) begin
         if (!r_bull_mask[j] && !r_used[j] && (w_sec_dig[j] == w_gss_dig[r_step])) begin
            w_found = 1'b1;
            w_match = STEP_W'(j);
         end
      end
   end

   assign w_tries_nxt = (r_tries >= 4'(MAX_TRIES)) ? r_tries : r_tries + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_secret       <= '0;
         r_guess        <= '0;
         r_bull_mask    <= '0;
         r_used         <= '0;
         r_step         <= '0;
         r_bull_cnt     <= 4'd0;
         r_cow_cnt      <= 4'd0;
         r_bulls        <= 4'd0;
         r_cows         <= 4'd0;
         r_tries        <= 4'd0;
         r_result_valid <= 1'b0;
         r_win          <= 1'b0;
         r_lose         <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (secret_load) begin
            r_secret <= secret;
            r_state  <= READY;
            r_bulls  <= 4'd0;
            r_cows   <= 4'd0;
            r_tries  <= 4'd0;
            r_win    <= 1'b0;
            r_lose   <= 1'b0;
         end else begin
            case (r_state)
               READY: begin
                  if (guess_valid) begin
                     r_guess <= guess;
                     r_state <= BULL;
                  end
               end
               BULL: begin
                  r_bull_mask <= w_bull_mask;
                  r_bull_cnt  <= w_bull_pop;
                  r_cow_cnt   <= 4'd0;
                  r_used      <= '0;
                  r_step      <= '0;
                  r_state     <= COW;
               end
               COW: begin
                  if (!r_bull_mask[r_step] && w_found) begin
                     r_used[w_match] <= 1'b1;
                     r_cow_cnt       <= r_cow_cnt + 4'd1;
                  end
                  if (r_step == STEP_W'(DIGITS - 1)) r_state <= DONE;
                  else r_step <= r_step + STEP_W'(1);
               end
               DONE: begin
                  r_result_valid <= 1'b1;
                  r_bulls        <= r_bull_cnt;
                  r_cows         <= r_cow_cnt;
                  r_tries        <= w_tries_nxt;
                  if (r_bull_cnt == 4'(DIGITS)) begin
                     r_win   <= 1'b1;
                     r_state <= WON;
                  end else if (w_tries_nxt == 4'(MAX_TRIES)) begin
                     r_lose  <= 1'b1;
                     r_state <= LOST;
                  end else begin
                     r_state <= READY;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan    <= '0;
         r_dig_idx <= 2'd0;
      end else if (r_scan == SCAN_W'(SCAN_DIV - 1)) begin
         r_scan    <= '0;
         r_dig_idx <= r_dig_idx + 2'd1;
      end else begin
         r_scan    <= r_scan + SCAN_W'(1);
      end
   end

   always_comb begin
      w_digit_val = 4'h1;
      case (r_dig_idx)
         2'd3: w_digit_val = r_bulls;
         2'd2: w_digit_val = r_cows;
         2'd1: w_digit_val = r_tries;
         default: begin
            case (r_state)
               IDLE:    w_digit_val = 4'h0;
               WON:     w_digit_val = 4'hA;
               LOST:    w_digit_val = 4'hF;
               default: w_digit_val = 4'h1;
            endcase
         end
      endcase
   end

   sevenSegment u_seg (
      .i_num (w_digit_val),
      .o_ssd (SSD)
   );

   assign d            = ~(4'b0001 << r_dig_idx);
   assign guess_ready  = (r_state == READY);
   assign bulls        = r_bulls;
   assign cows         = r_cows;
   assign tries        = r_tries;
   assign result_valid = r_result_valid;
   assign win          = r_win;
   assign lose         = r_lose;
endmodule
